// File: rtl/mem_pkg.sv
// Shared types, constants and lane helpers for the memory access unit.
// The optional read-modify-write path is selected with MEM_ACCESS_RMW_EN.
package mem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned F3_W_B = 3;

    localparam logic [XLEN-1:0] GPIO_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [F3_W_B-1:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        OPLEN_BYTE = 2'd0,
        OPLEN_HALF = 2'd1,
        OPLEN_WORD = 2'd2
    } oplen_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_RESP
    } state_e;

    // Request fields held for the life of one transaction.
    typedef struct packed {
        logic [F3_W_B-1:0] funct3;
        logic [XLEN-1:0]   addr;
        logic [RD_W-1:0]   rd;
    } mem_req_t;

    function automatic oplen_e oplen_of(input logic [F3_W_B-1:0] funct3);
        case (funct3)
            F3_B, F3_BU: return OPLEN_BYTE;
            F3_H, F3_HU: return OPLEN_HALF;
            default:     return OPLEN_WORD;
        endcase
    endfunction

    function automatic logic is_sub_word(input logic [F3_W_B-1:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [F3_W_B-1:0] funct3, input logic [1:0] lo);
        case (funct3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return |lo;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] lane_shift(input logic [F3_W_B-1:0] funct3, input logic [1:0] lo);
        case (funct3)
            F3_B, F3_BU: return {lo, 3'b000};
            F3_H, F3_HU: return {lo[1], 4'b0000};
            default:     return 5'd0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_mask(input logic [F3_W_B-1:0] funct3, input logic [1:0] lo);
        case (funct3)
            F3_B, F3_BU: return 32'h0000_00FF << lane_shift(funct3, lo);
            F3_H, F3_HU: return 32'h0000_FFFF << lane_shift(funct3, lo);
            default:     return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Store data moved onto its byte lanes, other lanes zero.
    function automatic logic [XLEN-1:0] store_lane(input logic [XLEN-1:0] wdata,
                                                   input logic [F3_W_B-1:0] funct3,
                                                   input logic [1:0] lo);
        return (wdata << lane_shift(funct3, lo)) & lane_mask(funct3, lo);
    endfunction

    // Sub-word store data merged into a previously read word.
    function automatic logic [XLEN-1:0] merge_lane(input logic [XLEN-1:0] word,
                                                   input logic [XLEN-1:0] wdata,
                                                   input logic [F3_W_B-1:0] funct3,
                                                   input logic [1:0] lo);
        return (word & ~lane_mask(funct3, lo)) | store_lane(wdata, funct3, lo);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data lane selection with sign/zero extension; bypass returns the raw word.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0]   word,
    input  logic [1:0]        lane,
    input  logic [F3_W_B-1:0] funct3,
    input  logic              bypass,
    output logic [XLEN-1:0]   data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {lane, 3'b000});
        half_sel = lane[1] ? word[31:16] : word[15:0];
        data_c   = word;
        if (!bypass) begin
            case (funct3)
                F3_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   data_c = {24'd0, byte_sel};
                F3_H:    data_c = {{16{half_sel[15]}}, half_sel};
                F3_HU:   data_c = {16'd0, half_sel};
                default: data_c = word;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-port RAM with timeout.
// Define MEM_ACCESS_RMW_EN to turn byte/half stores into read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [F3_W_B-1:0] req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic [RD_W-1:0]   resp_rd,
    output logic              resp_err,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [1:0]        mem_oplen,
    output logic [XLEN-1:0]   mem_data,
    input  logic              mem_valid,
    input  logic [XLEN-1:0]   mem_result
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              rmw_q, rmw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic [RD_W-1:0]   resp_rd_q, resp_rd_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    oplen_e            mem_oplen_q, mem_oplen_d;
    logic [XLEN-1:0]   mem_data_q, mem_data_d;

    logic              gpio_in_c, misalign_in_c, rmw_in_c, gpio_q_c, expired_c;
    oplen_e            acc_oplen_c;
    logic [XLEN-1:0]   load_c;

    mem_load_align u_load_align (
        .word   (mem_result),
        .lane   (req_q.addr[1:0]),
        .funct3 (req_q.funct3),
        .bypass (gpio_q_c),
        .data_c (load_c)
    );

    always_comb begin
        gpio_in_c     = (req_addr == GPIO_ADDR);
        misalign_in_c = !gpio_in_c && misaligned(req_funct3, req_addr[1:0]);
`ifdef MEM_ACCESS_RMW_EN
        rmw_in_c      = req_we && !gpio_in_c && is_sub_word(req_funct3);
`else
        rmw_in_c      = 1'b0;
`endif
        gpio_q_c      = (req_q.addr == GPIO_ADDR);
        // RMW and GPIO accesses always move a full word.
        acc_oplen_c   = (rmw_q || gpio_q_c) ? OPLEN_WORD : oplen_of(req_q.funct3);
        expired_c     = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        data_d       = data_q;
        rmw_d        = rmw_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        mem_enable_d = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_oplen_d  = mem_oplen_q;
        mem_data_d   = mem_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d       = '{funct3: req_funct3, addr: req_addr, rd: req_rd};
                    rmw_d       = rmw_in_c;
                    data_d      = (gpio_in_c || rmw_in_c) ? req_wdata
                                                          : store_lane(req_wdata, req_funct3, req_addr[1:0]);
                    req_ready_d = 1'b0;
                    if (misalign_in_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                        resp_rd_d    = req_rd;
                    end else if (req_we && !rmw_in_c) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_enable_d = 1'b1;
                mem_we_d     = 1'b0;
                mem_addr_d   = req_q.addr;
                mem_oplen_d  = acc_oplen_c;
                cnt_d        = '0;
                state_d      = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_valid && rmw_q) begin
                    data_d  = merge_lane(mem_result, data_q, req_q.funct3, req_q.addr[1:0]);
                    state_d = ST_WR;
                end else if (mem_valid || expired_c) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !mem_valid;
                    resp_data_d  = mem_valid ? load_c : '0;
                    resp_rd_d    = req_q.rd;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_WR: begin
                mem_enable_d = 1'b1;
                mem_we_d     = 1'b1;
                mem_addr_d   = req_q.addr;
                mem_oplen_d  = acc_oplen_c;
                mem_data_d   = data_q;
                cnt_d        = '0;
                state_d      = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mem_valid || expired_c) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !mem_valid;
                    resp_data_d  = '0;
                    resp_rd_d    = req_q.rd;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            data_q       <= '0;
            rmw_q        <= 1'b0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_oplen_q  <= OPLEN_BYTE;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            data_q       <= data_d;
            rmw_q        <= rmw_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            mem_enable_q <= mem_enable_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_oplen_q  <= mem_oplen_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;
    assign mem_enable = mem_enable_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_oplen  = mem_oplen_q;
    assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores, misalignment,
// GPIO, timeout boundary, reset abort; RAM responder with programmable delay.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_enable;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_oplen;
    logic [31:0] mem_data;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_result = '0;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr), .mem_oplen(mem_oplen),
        .mem_data(mem_data), .mem_valid(mem_valid), .mem_result(mem_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  oplen;
        logic [31:0] data;
        logic        chk_data;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        int          lat;
    } resp_t;

    acc_t  acc_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    accept_cyc = 0;
    int    ram_delay = 1;
    int    ram_cd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM model: answers ram_delay cycles after the strobe cycle (0 = never).
    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (!rst && mem_enable) begin
            ram_cd = ram_delay;
        end else if (ram_cd > 0) begin
            ram_cd = ram_cd - 1;
            if (ram_cd == 0) mem_valid = 1'b1;
        end
        if (rst) ram_cd = 0;
    end

    // Monitor: pops expected accesses/responses whenever the DUT presents one.
    always @(negedge clk) begin
        acc_t  a;
        resp_t r;
        if (!rst && mem_enable) begin
            if (acc_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_mem_enable: got addr 0x%08h expected no access", mem_addr);
            end else begin
                a = acc_q.pop_front();
                chk("mem_we", 32'(mem_we), 32'(a.we));
                chk("mem_addr", mem_addr, a.addr);
                chk("mem_oplen", 32'(mem_oplen), 32'(a.oplen));
                if (a.chk_data) chk("mem_data", mem_data, a.data);
            end
        end
        if (!rst && resp_valid) begin
            if (resp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: got data 0x%08h expected no response", resp_data);
            end else begin
                r = resp_q.pop_front();
                chk("resp_data", resp_data, r.data);
                chk("resp_rd", 32'(resp_rd), 32'(r.rd));
                chk("resp_err", 32'(resp_err), 32'(r.err));
                if (r.lat >= 0) chk("resp_latency", 32'(cyc - accept_cyc), 32'(r.lat));
            end
        end
    end

    task automatic push_acc(input logic we, input logic [31:0] addr, input logic [1:0] oplen,
                            input logic [31:0] data, input logic chk_data);
        acc_t a;
        a.we = we; a.addr = addr; a.oplen = oplen; a.data = data; a.chk_data = chk_data;
        acc_q.push_back(a);
    endtask

    task automatic push_resp(input logic [31:0] data, input logic [4:0] rd, input logic err, input int lat);
        resp_t r;
        r.data = data; r.rd = rd; r.err = err; r.lat = lat;
        resp_q.push_back(r);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        accept_cyc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (acc_q.size() == 0 && resp_q.size() == 0 && req_ready) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout: got %0d accesses %0d responses pending expected 0",
                     acc_q.size(), resp_q.size());
            acc_q.delete();
            resp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_oplen", 32'(mem_oplen), 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        rst = 1'b0;

        // Word load, 1-cycle RAM: response 3 cycles after accept.
        mem_result = 32'hDEAD_BEEF;
        push_acc(1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        push_resp(32'hDEAD_BEEF, 5'd5, 1'b0, 3);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd5);
        wait_idle();

        // Sub-word loads with lane select and extension.
        mem_result = 32'h80FF_1234;
        push_acc(1'b0, 32'h13, 2'd0, 32'h0, 1'b0);
        push_resp(32'hFFFF_FF80, 5'd6, 1'b0, 3);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd6);
        wait_idle();
        push_acc(1'b0, 32'h13, 2'd0, 32'h0, 1'b0);
        push_resp(32'h0000_0080, 5'd7, 1'b0, 3);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd7);
        wait_idle();
        push_acc(1'b0, 32'h12, 2'd1, 32'h0, 1'b0);
        push_resp(32'h0000_80FF, 5'd8, 1'b0, 3);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 5'd8);
        wait_idle();
        push_acc(1'b0, 32'h12, 2'd1, 32'h0, 1'b0);
        push_resp(32'hFFFF_80FF, 5'd9, 1'b0, 3);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd9);
        wait_idle();

        // Misaligned half load and word store: error, no RAM access.
        push_resp(32'h0, 5'd10, 1'b1, 0);
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 5'd10);
        wait_idle();
        push_resp(32'h0, 5'd11, 1'b1, 0);
        do_req(1'b1, 3'b010, 32'h13, 32'h1234_5678, 5'd11);
        wait_idle();

        // GPIO store and byte load: single word access, no alignment, raw data back.
        push_acc(1'b1, 32'hFFFF_FFFF, 2'd2, 32'h0000_A5A5, 1'b1);
        push_resp(32'h0, 5'd12, 1'b0, 3);
        do_req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0000_A5A5, 5'd12);
        wait_idle();
        push_acc(1'b0, 32'hFFFF_FFFF, 2'd2, 32'h0, 1'b0);
        push_resp(32'h80FF_1234, 5'd13, 1'b0, 3);
        do_req(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 5'd13);
        wait_idle();

        // Sub-word stores.
        mem_result = 32'h1122_3344;
`ifdef MEM_ACCESS_RMW_EN
        push_acc(1'b0, 32'h21, 2'd2, 32'h0, 1'b0);
        push_acc(1'b1, 32'h21, 2'd2, 32'h1122_AB44, 1'b1);
        push_resp(32'h0, 5'd14, 1'b0, 6);
        do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 5'd14);
        wait_idle();
        push_acc(1'b0, 32'h22, 2'd2, 32'h0, 1'b0);
        push_acc(1'b1, 32'h22, 2'd2, 32'hABCD_3344, 1'b1);
        push_resp(32'h0, 5'd15, 1'b0, 6);
        do_req(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 5'd15);
        wait_idle();
`else
        push_acc(1'b1, 32'h21, 2'd0, 32'h0000_AB00, 1'b1);
        push_resp(32'h0, 5'd14, 1'b0, 3);
        do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 5'd14);
        wait_idle();
        push_acc(1'b1, 32'h22, 2'd1, 32'hABCD_0000, 1'b1);
        push_resp(32'h0, 5'd15, 1'b0, 3);
        do_req(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 5'd15);
        wait_idle();
`endif

        // RAM answers on the last allowed cycle: success.
        ram_delay = 15;
        mem_result = 32'hCAFE_F00D;
        push_acc(1'b0, 32'h44, 2'd2, 32'h0, 1'b0);
        push_resp(32'hCAFE_F00D, 5'd16, 1'b0, 17);
        do_req(1'b0, 3'b010, 32'h44, 32'h0, 5'd16);
        wait_idle();

        // RAM never answers: timeout 16 cycles after the strobe.
        ram_delay = 0;
        push_acc(1'b0, 32'h40, 2'd2, 32'h0, 1'b0);
        push_resp(32'h0, 5'd17, 1'b1, 17);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd17);
        wait_idle();

        // RAM answers one cycle too late on a store, then a stray completion in IDLE.
        ram_delay = 18;
        push_acc(1'b1, 32'h48, 2'd2, 32'h5555_AAAA, 1'b1);
        push_resp(32'h0, 5'd18, 1'b1, 17);
        do_req(1'b1, 3'b010, 32'h48, 32'h5555_AAAA, 5'd18);
        wait_idle();
        repeat (6) @(negedge clk);
        chk("stray_req_ready", 32'(req_ready), 32'd1);

        // Reset while waiting for the RAM abandons the load.
        ram_delay = 0;
        push_acc(1'b0, 32'h50, 2'd2, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h50, 32'h0, 5'd19);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_mem_enable", 32'(mem_enable), 32'd0);
        repeat (20) @(negedge clk);
        chk("abort_pending_acc", 32'(acc_q.size()), 32'd0);

        ram_delay = 1;
        mem_result = 32'h0BAD_F00D;
        push_acc(1'b0, 32'h54, 2'd2, 32'h0, 1'b0);
        push_resp(32'h0BAD_F00D, 5'd20, 1'b0, 3);
        do_req(1'b0, 3'b010, 32'h54, 32'h0, 5'd20);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, max cycles waited for mem_valid after mem_enable before error.
REQ-002 clk  input  1  sole clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  pipeline offers a load/store.
REQ-005 req_ready  output  1  unit idle, can accept request.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, low-aligned.
REQ-010 req_rd  input  5  destination register tag, echoed on response.
REQ-011 resp_valid  output  1  one-cycle pulse, response present.
REQ-012 resp_data  output  32  load result, extended per funct3; 0 for stores/errors.
REQ-013 resp_rd  output  5  echoed req_rd.
REQ-014 resp_err  output  1  misaligned or timeout; qualifies resp_valid.
REQ-015 mem_enable, mem_we  output  1 each  RAM access strobe and write flag.
REQ-016 mem_addr  output  32; mem_oplen  output  2 (0 byte, 1 half, 2 word); mem_data  output  32.
REQ-017 mem_valid  input  1; mem_result  input  32  RAM completion and full read word.

Function
REQ-018 Request accepted on posedge where req_valid & req_ready; all req_* fields captured then; req_ready low until the cycle after resp_valid.
REQ-019 FSM states IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP; all outputs registered.
REQ-020 mem_enable is high for exactly one cycle per RAM access; never re-asserted while waiting.
REQ-021 Load: IDLE->RD (mem_enable, mem_we=0, mem_addr=req_addr)->RD_WAIT->RESP; word load with 1-cycle RAM gives resp_valid 3 cycles after acceptance.
REQ-022 Load extraction: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-023 Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0): no RAM access, RESP next cycle, resp_err=1, resp_data=0.
REQ-024 Address 32'hFFFFFFFF (GPIO) exempt from misalignment check and RMW; forwarded as single access with mem_oplen=2; load result returned unextended.
REQ-025 Word store: IDLE->WR (mem_we=1, mem_data=req_wdata)->WR_WAIT->RESP.
REQ-026 Timeout: counter cleared on each mem_enable; if mem_valid absent for TIMEOUT_CYCLES cycles in a WAIT state -> RESP with resp_err=1; a later stray mem_valid is ignored in IDLE.
REQ-027 mem_valid in a WAIT state on the same cycle the counter expires counts as success.
REQ-028 resp_valid asserted for exactly one cycle in RESP; FSM then returns to IDLE.

Reset
REQ-029 rst: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, resp_rd=0, mem_enable=0, mem_we=0, mem_addr=0, mem_oplen=0, mem_data=0, counter=0.
REQ-030 rst mid-operation abandons the transaction: no response, no further RAM access.

Configuration
REQ-031 Macro MEM_ACCESS_RMW_EN defined: B/H stores do read-modify-write: RD->RD_WAIT, merge wdata byte/half into mem_result lane, WR->WR_WAIT->RESP.
REQ-032 Macro absent: B/H stores issue one write, mem_oplen=0/1, mem_data = wdata lane-shifted per addr[1:0], no read.

Structure
REQ-033 Shared package mem_pkg: funct3 width enum, oplen enum, FSM state enum, GPIO_ADDR constant.
REQ-034 One sub-module mem_load_align: combinational lane select and sign/zero extension.

Verification
REQ-035 LW addr 0x10, mem_result 0xDEADBEEF in 1 cycle -> resp_valid 3 cycles after accept, resp_data 0xDEADBEEF, resp_err=0.
REQ-036 LB addr 0x13, mem_result 0x80FF1234 -> resp_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x12 -> 0x000080FF.
REQ-037 LH addr 0x11 -> no mem_enable, resp_err=1, resp_data=0; SW addr 0xFFFFFFFF data 0x0000A5A5 -> mem_we=1, mem_oplen=2, resp_err=0.
REQ-038 RMW_EN: SB addr 0x21 data 0xAB, read returns 0x11223344 -> write mem_data 0x1122AB44 at 0x21.
REQ-039 mem_valid withheld -> resp_err=1 exactly TIMEOUT_CYCLES(16) cycles after mem_enable; late mem_valid ignored.
REQ-040 rst in RD_WAIT -> next cycle req_ready=1, no resp_valid; new LW completes normally.
